cart_mem_responder: RTL
=======================

Name: cart_mem_responder

Overview:
- Memory-side end of the cartridge ROM/BSRAM strobe bus driven by the SNES top level and its active mapper.
- Detects new ROM and BSRAM accesses from address/strobe changes and serialises them onto a single req/ack word backend (SDRAM controller port).
- Returns read data on ROM_Q / BSRAM_Q and keeps a one-entry ROM read line to absorb repeated fetches.

Parameters:
- MEM_AW, 25, backend byte-address width.
- BSRAM_BASE, 25'h1000000, backend byte offset of the BSRAM region; ROM occupies 0..16MB-1.

Ports:
- MCLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ROM_ADDR  in  24  ROM byte address.
- ROM_D  in  16  ROM write data; only [7:0] is used.
- ROM_CE_N, ROM_OE_N, ROM_WE_N  in  1 each  ROM strobes, active low.
- ROM_WORD  in  1  1 = 16-bit read, 0 = byte access.
- ROM_Q  out  16  ROM read data.
- BSRAM_ADDR  in  20  BSRAM byte address.
- BSRAM_D  in  8  BSRAM write data.
- BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N  in  1 each  BSRAM strobes, active low.
- BSRAM_Q  out  8  BSRAM read data.
- BUSY  out  1  high while any access is pending or in flight; for debug and verification.
- MEM_ADDR  out  MEM_AW  backend byte address; bit 0 is always 0.
- MEM_WDATA  out  16  backend write data.
- MEM_BE  out  2  byte enables; [0] = even (low) byte.
- MEM_WE  out  1  1 = write.
- MEM_REQ  out  1  request.
- MEM_ACK  in  1  one-cycle completion pulse.
- MEM_RDATA  in  16  read data, valid with MEM_ACK.

Behaviour:
- Reset values: ROM_Q=0, BSRAM_Q=0, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_ADDR=0, MEM_WDATA=0, BUSY=0. All pending flags and the line-valid flag are cleared.
- Reset mid-access drops MEM_REQ immediately. The backend must tolerate an abandoned request.
- Access detection, evaluated per port every cycle:
  - Tuple = {CE_N, OE_N, WE_N, ADDR, WORD}; BSRAM has no WORD field.
  - Active read: CE_N=0, OE_N=0, WE_N=1. Active write: CE_N=0, WE_N=0.
  - A trigger fires when the tuple is active and differs from the previous cycle's registered tuple.
  - A write whose data changes while its tuple is held does not retrigger.
- Pending slots: one per port. A new trigger overwrites an older unserviced entry for that port (latest wins). An access already granted always completes.
- Captured at trigger time: address, op, WORD, write data.
- FSM states: IDLE, ROM_RD, ROM_WR, BS_RD, BS_WR.
- In IDLE:
  - If both ports are pending, grant the port not granted last.
  - Otherwise grant the single pending port.
  - A ROM read that hits the line is completed in IDLE with no backend access.
- Grant cycle: the following are registered and held stable until MEM_ACK:
  - MEM_REQ=1 and MEM_ADDR:
    - ROM: {1'b0, addr[23:1], 1'b0}.
    - BSRAM: BSRAM_BASE + {addr[19:1], 1'b0}.
  - MEM_BE: 2'b11 for reads; {addr[0], ~addr[0]} for writes.
  - MEM_WDATA: {d[7:0], d[7:0]}.
- On MEM_ACK: MEM_REQ drops in the same edge and the FSM returns to IDLE.
  - A ROM_RD ack fills the line (tag = addr[23:1], valid = 1).
  - Back-to-back grants are allowed; MEM_REQ may rise the cycle after ack.
- ROM_Q update, one cycle after ack or after a hit decision:
  - WORD=1: MEM_RDATA.
  - WORD=0: selected byte duplicated in both halves. Byte = addr[0] ? rdata[15:8] : rdata[7:0].
- BSRAM_Q: selected byte, same addr[0] rule.
- ROM write whose word address equals the line tag: line invalidated. A BSRAM access never touches the line.
- Q outputs hold their last value between accesses.
- Latency:
  - Line hit: trigger -> ROM_Q in 2 cycles.
  - Miss: ack + 1 cycle.
- BUSY = any pending slot | FSM not IDLE.

Decomposition:
- Shared package cart_mem_pkg holds:
  - state enum {IDLE, ROM_RD, ROM_WR, BS_RD, BS_WR};
  - access struct {addr, we, word, wdata};
  - BSRAM_BASE default.
- One sub-module, cart_access_detect, instantiated twice (ROM, BSRAM): tuple register, trigger and pending slot. Its parameters are address width and WORD presence.

Test Plan:
- ROM word read 0x000102, backend returns 0xBEEF after 3 cycles -> MEM_ADDR=0x000102, BE=11, ROM_Q=0xBEEF; then a byte read of 0x000103 hits the line -> no MEM_REQ, ROM_Q=0xBEBE.
- BSRAM write 0x00005 data 0x5A -> MEM_ADDR=0x1000004, BE=10, WDATA=0x5A5A, WE=1; a later read of 0x00005 returning 0x5A00 -> BSRAM_Q=0x5A.
- ROM and BSRAM reads triggered in the same cycle, ROM last granted -> BSRAM served first, ROM immediately after ack, BUSY low only after both complete.
- Three ROM addresses 0x10, 0x20, 0x30 in consecutive cycles while the backend stalls 10 cycles -> exactly two requests, 0x10 then 0x30.
- ROM line holds tag 0x40; ROM write to 0x000081 -> line invalidated; the next read of 0x000080 issues MEM_REQ.
- RESET asserted while MEM_REQ=1 -> MEM_REQ, ROM_Q, BUSY go to 0 asynchronously; after release, a repeat of the same active tuple retriggers.

Source files
------------

// File: rtl/cart_mem_pkg.sv
// cart_mem_pkg: shared types for the cartridge ROM/BSRAM responder.
// FSM states, captured access record and read-data formatting.
package cart_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROM_RD,
    ROM_WR,
    BS_RD,
    BS_WR
  } state_t;

  typedef struct packed {
    logic [23:0] addr;
    logic        we;
    logic        word;
    logic [7:0]  wdata;
  } access_t;

  localparam logic [24:0] BSRAM_BASE_DEF = 25'h1000000;

  // Byte reads are returned duplicated in both halves.
  function automatic logic [15:0] fmt_q(
    input logic [15:0] d,
    input logic        lsb,
    input logic        word
  );
    logic [7:0] b;
    b = lsb ? d[15:8] : d[7:0];
    return word ? d : {b, b};
  endfunction

endpackage

// File: rtl/cart_access_detect.sv
// cart_access_detect: per-port strobe tuple tracker.
// Fires on a new active tuple and holds one latest-wins pending slot.
module cart_access_detect
  import cart_mem_pkg::*;
#(
  parameter int AW       = 24,
  parameter bit HAS_WORD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_n,
  input  logic          oe_n,
  input  logic          we_n,
  input  logic [AW-1:0] addr,
  input  logic          word,
  input  logic [7:0]    d,
  input  logic          take,
  output logic          pending,
  output access_t       acc
);

  localparam int TW = AW + 4;

  logic [TW-1:0] tup;
  logic [TW-1:0] tup_q;
  logic          wrd;
  logic          act_rd;
  logic          act_wr;
  logic          trig;

  assign wrd    = HAS_WORD ? word : 1'b0;
  assign tup    = {ce_n, oe_n, we_n, addr, wrd};
  assign act_rd = !ce_n && !oe_n && we_n;
  assign act_wr = !ce_n && !we_n;
  assign trig   = (act_rd || act_wr) && (tup != tup_q);

  // Reset to an inactive tuple so a held access retriggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tup_q   <= '1;
      pending <= 1'b0;
      acc     <= '0;
    end else begin
      tup_q <= tup;
      if (trig) begin
        pending   <= 1'b1;
        acc.addr  <= 24'(addr);
        acc.we    <= act_wr;
        acc.word  <= wrd;
        acc.wdata <= d;
      end else if (take) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cart_mem_responder.sv
// cart_mem_responder: serialises cartridge ROM/BSRAM accesses onto
// a single req/ack word backend, with a one-entry ROM read line.
module cart_mem_responder
  import cart_mem_pkg::*;
#(
  parameter int              MEM_AW     = 25,
  parameter logic [MEM_AW-1:0] BSRAM_BASE = MEM_AW'(BSRAM_BASE_DEF)
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic [23:0]       ROM_ADDR,
  input  logic [15:0]       ROM_D,
  input  logic              ROM_CE_N,
  input  logic              ROM_OE_N,
  input  logic              ROM_WE_N,
  input  logic              ROM_WORD,
  output logic [15:0]       ROM_Q,
  input  logic [19:0]       BSRAM_ADDR,
  input  logic [7:0]        BSRAM_D,
  input  logic              BSRAM_CE_N,
  input  logic              BSRAM_OE_N,
  input  logic              BSRAM_WE_N,
  output logic [7:0]        BSRAM_Q,
  output logic              BUSY,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic [15:0]       MEM_WDATA,
  output logic [1:0]        MEM_BE,
  output logic              MEM_WE,
  output logic              MEM_REQ,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_RDATA
);

  state_t      state;
  state_t      state_n;
  logic        rom_pend;
  logic        bs_pend;
  access_t     rom_acc;
  access_t     bs_acc;
  logic        take_rom;
  logic        take_bs;
  logic        hit;
  logic        line_hit;
  logic        last_rom;
  logic        line_vld;
  logic [22:0] line_tag;
  logic [15:0] line_data;
  logic        cur_lsb;
  logic        cur_word;
  logic [22:0] cur_tag;
  logic [7:0]  bs_byte;
  logic        unused_bits;

  assign unused_bits = ^{ROM_D[15:8], bs_acc.addr[23:20], bs_acc.word};

  cart_access_detect #(
    .AW       (24),
    .HAS_WORD (1'b1)
  ) u_rom_det (
    .clk     (MCLK),
    .rst     (RESET),
    .ce_n    (ROM_CE_N),
    .oe_n    (ROM_OE_N),
    .we_n    (ROM_WE_N),
    .addr    (ROM_ADDR),
    .word    (ROM_WORD),
    .d       (ROM_D[7:0]),
    .take    (take_rom),
    .pending (rom_pend),
    .acc     (rom_acc)
  );

  cart_access_detect #(
    .AW       (20),
    .HAS_WORD (1'b0)
  ) u_bs_det (
    .clk     (MCLK),
    .rst     (RESET),
    .ce_n    (BSRAM_CE_N),
    .oe_n    (BSRAM_OE_N),
    .we_n    (BSRAM_WE_N),
    .addr    (BSRAM_ADDR),
    .word    (1'b0),
    .d       (BSRAM_D),
    .take    (take_bs),
    .pending (bs_pend),
    .acc     (bs_acc)
  );

  assign line_hit = line_vld && (line_tag == rom_acc.addr[23:1]);
  assign bs_byte  = cur_lsb ? MEM_RDATA[15:8] : MEM_RDATA[7:0];
  assign BUSY     = rom_pend || bs_pend || (state != IDLE);

  // Round-robin between ports when both are pending.
  always_comb begin
    state_n  = state;
    take_rom = 1'b0;
    take_bs  = 1'b0;
    hit      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rom_pend && (!bs_pend || !last_rom)) begin
          take_rom = 1'b1;
          if (rom_acc.we) begin
            state_n = ROM_WR;
          end else if (line_hit) begin
            hit = 1'b1;
          end else begin
            state_n = ROM_RD;
          end
        end else if (bs_pend) begin
          take_bs = 1'b1;
          state_n = bs_acc.we ? BS_WR : BS_RD;
        end
      end
      default: begin
        if (MEM_ACK) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      MEM_REQ   <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_BE    <= '0;
      MEM_WE    <= 1'b0;
      MEM_WDATA <= '0;
      ROM_Q     <= '0;
      BSRAM_Q   <= '0;
      last_rom  <= 1'b0;
      line_vld  <= 1'b0;
      line_tag  <= '0;
      line_data <= '0;
      cur_lsb   <= 1'b0;
      cur_word  <= 1'b0;
      cur_tag   <= '0;
    end else begin
      state <= state_n;
      if (take_rom) begin
        last_rom <= 1'b1;
        cur_lsb  <= rom_acc.addr[0];
        cur_word <= rom_acc.word;
        cur_tag  <= rom_acc.addr[23:1];
      end
      if (take_rom && !hit) begin
        MEM_REQ   <= 1'b1;
        MEM_ADDR  <= MEM_AW'({rom_acc.addr[23:1], 1'b0});
        MEM_WE    <= rom_acc.we;
        MEM_WDATA <= {2{rom_acc.wdata}};
        MEM_BE    <= rom_acc.we ?
                     {rom_acc.addr[0], ~rom_acc.addr[0]} : 2'b11;
        if (rom_acc.we && line_hit) line_vld <= 1'b0;
      end
      if (hit) begin
        ROM_Q <= fmt_q(line_data, rom_acc.addr[0], rom_acc.word);
      end
      if (take_bs) begin
        last_rom  <= 1'b0;
        cur_lsb   <= bs_acc.addr[0];
        cur_word  <= 1'b0;
        MEM_REQ   <= 1'b1;
        MEM_ADDR  <= BSRAM_BASE +
                     MEM_AW'({bs_acc.addr[19:1], 1'b0});
        MEM_WE    <= bs_acc.we;
        MEM_WDATA <= {2{bs_acc.wdata}};
        MEM_BE    <= bs_acc.we ?
                     {bs_acc.addr[0], ~bs_acc.addr[0]} : 2'b11;
      end
      if ((state != IDLE) && MEM_ACK) begin
        MEM_REQ <= 1'b0;
        if (state == ROM_RD) begin
          ROM_Q     <= fmt_q(MEM_RDATA, cur_lsb, cur_word);
          line_vld  <= 1'b1;
          line_tag  <= cur_tag;
          line_data <= MEM_RDATA;
        end
        if (state == BS_RD) BSRAM_Q <= bs_byte;
      end
    end
  end

endmodule
